fifo_serializer: RTL and testbench

Downstream drain stage for the 32-bit FIFO. Pops words from a first-word-fall-through FIFO whenever it is idle and the FIFO is non-empty. Transmits each word on a single-bit line as a framed serial character: start bit, DWIDTH data bits LSB first, optional parity bit, stop bit. Sits between the FIFO read port and the board-level serial output.

---
 rtl/fifo_serializer_pkg.sv | 13 +
 rtl/fifo_serializer_bittimer.sv | 17 +
 rtl/fifo_serializer.sv | 99 +++++++++
 tb/tb_fifo_serializer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_serializer_pkg.sv
// fifo_serializer_pkg: shared state encoding and serial line levels for fifo_serializer.
package fifo_serializer_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } ser_state_t;
    localparam logic SER_START_BIT  = 1'b0;
    localparam logic SER_STOP_BIT   = 1'b1;
    localparam logic SER_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/fifo_serializer_bittimer.sv
// fifo_serializer_bittimer: counts CLKDIV cycles per serial bit and pulses bit_done on the last one.
// Ports: clk (rising edge), res (sync active-high reset), restart (zero the count),
//        bit_done (high during the final cycle of each bit period).
module fifo_serializer_bittimer #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic res,
    input  logic restart,
    output logic bit_done
);
    localparam int TW = CLKDIV > 1 ? $clog2(CLKDIV) : 1;
    logic [TW-1:0] cnt;
    assign bit_done = cnt == TW'(CLKDIV - 1);
    always_ff @(posedge clk)
        cnt <= (res || restart || bit_done) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_serializer.sv
// fifo_serializer: drains an FWFT FIFO and sends each word as start, LSB-first data, optional parity, stop.
// Ports: clk, res (sync active-high reset), enable (permit new pops), fifo_empty, fifo_data (FWFT head),
//        fifo_shiftout (pop strobe), tx (registered serial line, idle high), busy (frame in flight),
//        frame_cnt (completed frames, wrapping).
// Build option: define FIFO_SERIALIZER_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_serializer
    import fifo_serializer_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int CLKDIV = 4
) (
    input  logic              clk,
    input  logic              res,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_shiftout,
    output logic              tx,
    output logic              busy,
    output logic [15:0]       frame_cnt
);
    localparam int BW = DWIDTH > 1 ? $clog2(DWIDTH) : 1;
    ser_state_t        state;
    logic [DWIDTH-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic              bit_done;
    logic              last_bit;
`ifdef FIFO_SERIALIZER_PARITY_EN
    logic              par;
`endif
    assign fifo_shiftout = state == IDLE && enable && !fifo_empty && !res;
    assign busy          = state != IDLE;
    assign last_bit      = bit_cnt == BW'(DWIDTH - 1);
    // Every state lasts a whole number of bit periods, so the timer only needs
    // zeroing when a frame starts; it wraps onto each later state entry by itself.
    fifo_serializer_bittimer #(.CLKDIV(CLKDIV)) u_timer (
        .clk      (clk),
        .res      (res),
        .restart  (fifo_shiftout),
        .bit_done (bit_done)
    );
    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            tx        <= SER_IDLE_LEVEL;
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
`ifdef FIFO_SERIALIZER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (fifo_shiftout) begin
                    state   <= START;
                    shreg   <= fifo_data;
                    bit_cnt <= '0;
                    tx      <= SER_START_BIT;
`ifdef FIFO_SERIALIZER_PARITY_EN
                    par     <= ^fifo_data;
`endif
                end
                START: if (bit_done) begin
                    state <= DATA;
                    tx    <= shreg[0];
                end
                DATA: if (bit_done) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
                        state <= PARITY;
                        tx    <= par;
`else
                        state <= STOP;
                        tx    <= SER_STOP_BIT;
`endif
                    end else begin
                        tx <= shreg[1];
                    end
                end
`ifdef FIFO_SERIALIZER_PARITY_EN
                PARITY: if (bit_done) begin
                    state <= STOP;
                    tx    <= SER_STOP_BIT;
                end
`endif
                STOP: if (bit_done) begin
                    state     <= IDLE;
                    frame_cnt <= frame_cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    tx    <= SER_IDLE_LEVEL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: directed bench for fifo_serializer fed by a small FWFT FIFO model.
module tb_fifo_serializer;
    localparam int DW = 32;
    localparam int CLKDIV = 4;
`ifdef FIFO_SERIALIZER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = (DW + 2 + P) * CLKDIV;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty;
    logic          fifo_shiftout;
    logic          tx;
    logic          busy;
    logic [DW-1:0] fifo_data;
    logic [15:0]   frame_cnt;
    logic [DW-1:0] mem [64];
    int rd = 0;
    int wr = 0;
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    int exp_frames = 0;
    int last_pop = 0;
    logic [DW-1:0] words [8] = '{32'h00000000, 32'hFFFFFFFF, 32'h12345678, 32'h80000001,
                                 32'hDEADBEEF, 32'h00000007, 32'h55555555, 32'hCAFEF00D};
    logic          pars  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    fifo_serializer #(.DWIDTH(DW), .CLKDIV(CLKDIV)) dut (
        .clk           (clk),
        .res           (res),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_data     (fifo_data),
        .fifo_shiftout (fifo_shiftout),
        .tx            (tx),
        .busy          (busy),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_shiftout) rd <= rd + 1;
    end
    assign fifo_empty = rd == wr;
    assign fifo_data  = mem[rd[5:0]];

    task push(input logic [DW-1:0] w);
        mem[wr[5:0]] = w;
        wr++;
    endtask

    function automatic logic exp_tx(input logic [DW-1:0] w, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= DW) return w[pos-1];
        if (P == 1 && pos == DW + 1) return ^w;
        return 1'b1;
    endfunction

    task automatic run_frame(input logic [DW-1:0] w, input logic exp_par, input int drop_at, input bit chk_gap);
        int n, errs, busy_n, pops, p;
        logic [DW-1:0] rx;
        logic rpar;
        n = 0;
        while (fifo_shiftout !== 1'b1 && n < 400) begin
            @(posedge clk); @(negedge clk); n++;
        end
        compared++;
        if (fifo_shiftout !== 1'b1) begin
            mismatched++;
            $display("FAIL pop_timeout: fifo_shiftout=%b after %0d cycles, required 1", fifo_shiftout, n);
        end
        if (chk_gap) begin
            compared++;
            if (cyc - last_pop !== F + 1) begin
                mismatched++;
                $display("FAIL pop_spacing: %0d cycles, required %0d", cyc - last_pop, F + 1);
            end
        end
        last_pop = cyc;
        errs = 0; busy_n = 0; pops = 0; rx = '0; rpar = 1'b0;
        for (int i = 0; i < F; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == drop_at) enable = 1'b0;
            if (tx !== exp_tx(w, i / CLKDIV)) errs++;
            if (busy === 1'b1) busy_n++;
            if (fifo_shiftout !== 1'b0) pops++;
            if (i % CLKDIV == CLKDIV / 2) begin
                p = i / CLKDIV;
                if (p >= 1 && p <= DW) rx[p-1] = tx;
                if (p == DW + 1) rpar = tx;
            end
        end
        exp_frames++;
        compared += 5;
        if (errs !== 0) begin
            mismatched++;
            $display("FAIL tx_wave %h: %0d wrong cycles, required 0", w, errs);
        end
        if (busy_n !== F) begin
            mismatched++;
            $display("FAIL busy_len %h: %0d cycles, required %0d", w, busy_n, F);
        end
        if (pops !== 0) begin
            mismatched++;
            $display("FAIL extra_pop %h: %0d pops mid-frame, required 0", w, pops);
        end
        if (rx !== w) begin
            mismatched++;
            $display("FAIL rx_word: got %h, required %h", rx, w);
        end
        if (rpar !== (P == 1 ? exp_par : 1'b1)) begin
            mismatched++;
            $display("FAIL parity_bit %h: got %b, required %b", w, rpar, (P == 1 ? exp_par : 1'b1));
        end
        @(posedge clk); @(negedge clk);
        compared += 2;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            mismatched++;
            $display("FAIL post_idle: busy=%b tx=%b, required busy=0 tx=1", busy, tx);
        end
        if (frame_cnt !== exp_frames[15:0]) begin
            mismatched++;
            $display("FAIL frame_cnt: got %0d, required %0d", frame_cnt, exp_frames);
        end
    endtask

    task test_reset;
        res = 1'b1;
        enable = 1'b1;
        push(32'hA5A50003);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); @(negedge clk);
            compared++;
            if (tx !== 1'b1 || fifo_shiftout !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
                mismatched++;
                $display("FAIL reset_hold cycle %0d: tx=%b pop=%b busy=%b cnt=%0d, required 1/0/0/0",
                         i, tx, fifo_shiftout, busy, frame_cnt);
            end
        end
        enable = 1'b0;
        res = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        compared++;
        if (rd !== 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL disabled_no_pop: rd=%0d busy=%b, required 0/0", rd, busy);
        end
    endtask

    task test_single;
        enable = 1'b1;
        #1;
        run_frame(32'hA5A50003, 1'b0, -1, 1'b0);
        compared++;
        if (rd !== 1 || fifo_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL single_pop_count: rd=%0d empty=%b, required 1/1", rd, fifo_empty);
        end
    endtask

    task test_parity;
        push(32'h00000001);
        #1;
        run_frame(32'h00000001, 1'b1, -1, 1'b0);
    endtask

    task test_back_to_back;
        for (int i = 0; i < 8; i++) push(words[i]);
        #1;
        for (int i = 0; i < 8; i++) run_frame(words[i], pars[i], -1, i != 0);
        compared++;
        if (fifo_empty !== 1'b1 || rd !== wr) begin
            mismatched++;
            $display("FAIL b2b_drain: empty=%b rd=%0d, required 1 rd=%0d", fifo_empty, rd, wr);
        end
    endtask

    task test_enable_drop;
        int rd0, bad;
        for (int i = 0; i < 8; i++) push(words[i]);
        #1;
        for (int i = 0; i < 3; i++) run_frame(words[i], pars[i], i == 2 ? 40 : -1, i != 0);
        rd0 = rd;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (tx !== 1'b1 || fifo_shiftout !== 1'b0 || busy !== 1'b0) bad++;
            @(posedge clk); @(negedge clk);
        end
        compared += 2;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL paused_line: %0d bad cycles, required 0", bad);
        end
        if (rd !== rd0) begin
            mismatched++;
            $display("FAIL paused_pops: rd=%0d, required %0d", rd, rd0);
        end
        enable = 1'b1;
        #1;
        for (int i = 3; i < 8; i++) run_frame(words[i], pars[i], -1, i != 3);
    endtask

    task test_reset_mid;
        int n, rd0;
        push(32'h0F0F0F0F);
        push(32'h00000003);
        #1;
        n = 0;
        while (fifo_shiftout !== 1'b1 && n < 400) begin
            @(posedge clk); @(negedge clk); n++;
        end
        compared++;
        if (fifo_shiftout !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_pop_timeout: fifo_shiftout=%b, required 1", fifo_shiftout);
        end
        repeat (60) begin
            @(posedge clk); @(negedge clk);
        end
        res = 1'b1;
        rd0 = rd;
        @(posedge clk); @(negedge clk);
        compared++;
        if (tx !== 1'b1 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
            mismatched++;
            $display("FAIL abort_state: tx=%b busy=%b cnt=%0d, required 1/0/0", tx, busy, frame_cnt);
        end
        @(posedge clk); @(negedge clk);
        compared++;
        if (fifo_shiftout !== 1'b0 || rd !== rd0 || fifo_empty !== 1'b0) begin
            mismatched++;
            $display("FAIL pop_in_reset: pop=%b rd=%0d empty=%b, required 0 rd=%0d 0",
                     fifo_shiftout, rd, fifo_empty, rd0);
        end
        res = 1'b0;
        exp_frames = 0;
        #1;
        run_frame(32'h00000003, 1'b0, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
